// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: opcodes, instruction field positions and
// the hazard controller state encoding.
package pipeline_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam int OP_MSB = 31;
    localparam int OP_LSB = 26;
    localparam int RS_MSB = 25;
    localparam int RS_LSB = 21;
    localparam int RT_MSB = 20;
    localparam int RT_LSB = 16;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } hz_state_e;

    // Only these formats actually read rt as a source operand.
    function automatic logic op_uses_rt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/hazard_ctrl_unit_sat_counter.sv
// Saturating up-counter used for the stall/flush performance counters.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: load-use bubbles, branch/jump flushes and
// saturating performance counters. Outputs are Mealy (state + current inputs).
module hazard_ctrl_unit
    import pipeline_pkg::*;
#(
    parameter int LOAD_USE_STALL = 1,
    parameter int FLUSH_CYCLES   = 2,
    parameter int CNT_W          = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [31:0]      Instruction_ID,
    input  logic             MemRead_EX,
    input  logic [4:0]       rt_EX,
    input  logic             Branch_taken_MEM,
    input  logic             jump_ID,
    output logic             MUXCOntrol,
    output logic             ID_Flush,
    output logic             IF_Flush,
    output logic             PC_Write,
    output logic             IFID_Write,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [1:0] STALL_RELOAD = 2'(LOAD_USE_STALL - 1);
    localparam logic [1:0] FLUSH_RELOAD = 2'(FLUSH_CYCLES - 1);

    hz_state_e   state_q;
    hz_state_e   state_d;
    logic [1:0]  rem_q;
    logic [1:0]  rem_d;

    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        hz;
    logic        stall_inc;
    logic        flush_inc;

    assign opcode = Instruction_ID[OP_MSB:OP_LSB];
    assign rs     = Instruction_ID[RS_MSB:RS_LSB];
    assign rt     = Instruction_ID[RT_MSB:RT_LSB];

    // An all-zero instruction is a squashed slot and never creates a hazard.
    assign hz = MemRead_EX
              && (rt_EX != 5'd0)
              && (Instruction_ID != 32'd0)
              && ((rt_EX == rs) || (op_uses_rt(opcode) && (rt_EX == rt)));

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        MUXCOntrol = 1'b0;
        ID_Flush   = 1'b0;
        IF_Flush   = 1'b0;
        PC_Write   = 1'b1;
        IFID_Write = 1'b1;
        stall_inc  = 1'b0;
        flush_inc  = 1'b0;

        case (state_q)
            ST_RUN, ST_STALL: begin
                if (Branch_taken_MEM) begin
                    ID_Flush  = 1'b1;
                    IF_Flush  = 1'b1;
                    flush_inc = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_d = ST_FLUSH;
                        rem_d   = FLUSH_RELOAD;
                    end else begin
                        state_d = ST_RUN;
                        rem_d   = 2'd0;
                    end
                end else if ((state_q == ST_STALL) || hz) begin
                    MUXCOntrol = 1'b1;
                    PC_Write   = 1'b0;
                    IFID_Write = 1'b0;
                    stall_inc  = 1'b1;
                    if (state_q == ST_STALL) begin
                        rem_d = rem_q - 2'd1;
                        if (rem_q <= 2'd1) begin
                            state_d = ST_RUN;
                            rem_d   = 2'd0;
                        end
                    end else if (LOAD_USE_STALL > 1) begin
                        state_d = ST_STALL;
                        rem_d   = STALL_RELOAD;
                    end
                end else if (jump_ID) begin
                    IF_Flush  = 1'b1;
                    flush_inc = 1'b1;
                end
            end

            ST_FLUSH: begin
                // Squashed instructions are not allowed to stall or jump.
                ID_Flush = 1'b1;
                IF_Flush = 1'b1;
                if (Branch_taken_MEM) begin
                    flush_inc = 1'b1;
                    rem_d     = FLUSH_RELOAD;
                end else begin
                    rem_d = rem_q - 2'd1;
                    if (rem_q <= 2'd1) begin
                        state_d = ST_RUN;
                        rem_d   = 2'd0;
                    end
                end
            end

            default: begin
                state_d = ST_RUN;
                rem_d   = 2'd0;
            end
        endcase

        // Async reset must show its idle outputs immediately, not at the next edge.
        if (reset) begin
            MUXCOntrol = 1'b0;
            ID_Flush   = 1'b0;
            IF_Flush   = 1'b0;
            PC_Write   = 1'b1;
            IFID_Write = 1'b1;
            stall_inc  = 1'b0;
            flush_inc  = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_RUN;
            rem_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_flush_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (flush_inc),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Scoreboard bench for hazard_ctrl_unit: two instances (1-cycle stall with 4-bit
// counters, 3-cycle stall with 16-bit counters) driven by the same pipeline inputs.
module tb_hazard_ctrl_unit;
    import pipeline_pkg::*;

    typedef struct packed {
        logic        mux;
        logic        id_flush;
        logic        if_flush;
        logic        pc_write;
        logic        ifid_write;
        logic [15:0] stall_cnt;
        logic [15:0] flush_cnt;
    } exp_t;

    logic        clock       = 1'b0;
    logic        reset       = 1'b1;
    logic [31:0] instr_id    = '0;
    logic        mem_read_ex = 1'b0;
    logic [4:0]  rt_ex       = '0;
    logic        branch_mem  = 1'b0;
    logic        jump_id     = 1'b0;

    logic        mux_a, id_flush_a, if_flush_a, pc_write_a, ifid_write_a;
    logic [3:0]  stall_cnt_a, flush_cnt_a;
    logic        mux_b, id_flush_b, if_flush_b, pc_write_b, ifid_write_b;
    logic [15:0] stall_cnt_b, flush_cnt_b;

    int   num_checks = 0;
    int   num_fails  = 0;
    int   cycle      = 0;
    exp_t sb_q[$];

    int m_state [2];
    int m_rem   [2];
    int m_scnt  [2];
    int m_fcnt  [2];
    int p_ls    [2] = '{1, 3};
    int p_fc    [2] = '{2, 2};
    int p_max   [2] = '{15, 65535};

    logic [5:0] ops [7] = '{OP_RTYPE, OP_BEQ, OP_SW, OP_LW, OP_ADDI, OP_ANDI, OP_J};

    always #5 clock = ~clock;

    hazard_ctrl_unit #(
        .LOAD_USE_STALL (1),
        .FLUSH_CYCLES   (2),
        .CNT_W          (4)
    ) dut_a (
        .clock            (clock),
        .reset            (reset),
        .Instruction_ID   (instr_id),
        .MemRead_EX       (mem_read_ex),
        .rt_EX            (rt_ex),
        .Branch_taken_MEM (branch_mem),
        .jump_ID          (jump_id),
        .MUXCOntrol       (mux_a),
        .ID_Flush         (id_flush_a),
        .IF_Flush         (if_flush_a),
        .PC_Write         (pc_write_a),
        .IFID_Write       (ifid_write_a),
        .stall_cnt        (stall_cnt_a),
        .flush_cnt        (flush_cnt_a)
    );

    hazard_ctrl_unit #(
        .LOAD_USE_STALL (3),
        .FLUSH_CYCLES   (2),
        .CNT_W          (16)
    ) dut_b (
        .clock            (clock),
        .reset            (reset),
        .Instruction_ID   (instr_id),
        .MemRead_EX       (mem_read_ex),
        .rt_EX            (rt_ex),
        .Branch_taken_MEM (branch_mem),
        .jump_ID          (jump_id),
        .MUXCOntrol       (mux_b),
        .ID_Flush         (id_flush_b),
        .IF_Flush         (if_flush_b),
        .PC_Write         (pc_write_b),
        .IFID_Write       (ifid_write_b),
        .stall_cnt        (stall_cnt_b),
        .flush_cnt        (flush_cnt_b)
    );

    // Reference behaviour for instance i given the inputs currently driven.
    // Returns this cycle's expected outputs and advances the model to the next cycle.
    function automatic exp_t model_step(input int i);
        exp_t       e;
        logic [5:0] op;
        logic       ur, hz, sinc, finc;
        int         nst, nrem;
        op = instr_id[31:26];
        ur = (op == 6'b000000) || (op == 6'b000100) || (op == 6'b101011);
        hz = mem_read_ex && (rt_ex != 5'd0) && (instr_id != 32'd0)
             && ((rt_ex == instr_id[25:21]) || (ur && (rt_ex == instr_id[20:16])));
        e.mux = 1'b0; e.id_flush = 1'b0; e.if_flush = 1'b0;
        e.pc_write = 1'b1; e.ifid_write = 1'b1;
        if (reset) begin
            m_state[i] = 0; m_rem[i] = 0; m_scnt[i] = 0; m_fcnt[i] = 0;
            e.stall_cnt = '0; e.flush_cnt = '0;
            return e;
        end
        e.stall_cnt = 16'(m_scnt[i]);
        e.flush_cnt = 16'(m_fcnt[i]);
        sinc = 1'b0; finc = 1'b0;
        nst = m_state[i]; nrem = m_rem[i];
        if (m_state[i] != 2 && branch_mem) begin
            e.id_flush = 1'b1; e.if_flush = 1'b1; finc = 1'b1;
            if (p_fc[i] > 1) begin nst = 2; nrem = p_fc[i] - 1; end
            else begin nst = 0; nrem = 0; end
        end else if (m_state[i] == 1 || (m_state[i] == 0 && hz)) begin
            e.mux = 1'b1; e.pc_write = 1'b0; e.ifid_write = 1'b0; sinc = 1'b1;
            if (m_state[i] == 0) begin
                if (p_ls[i] > 1) begin nst = 1; nrem = p_ls[i] - 1; end
            end else begin
                nrem = m_rem[i] - 1;
                if (m_rem[i] == 1) nst = 0;
            end
        end else if (m_state[i] == 2) begin
            e.id_flush = 1'b1; e.if_flush = 1'b1;
            if (branch_mem) begin finc = 1'b1; nrem = p_fc[i] - 1; end
            else begin
                nrem = m_rem[i] - 1;
                if (m_rem[i] == 1) nst = 0;
            end
        end else if (jump_id) begin
            e.if_flush = 1'b1; finc = 1'b1;
        end
        if (sinc && m_scnt[i] < p_max[i]) m_scnt[i]++;
        if (finc && m_fcnt[i] < p_max[i]) m_fcnt[i]++;
        m_state[i] = nst;
        m_rem[i]   = nrem;
        return e;
    endfunction

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        num_checks++;
        if (obs !== exp) begin
            num_fails++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic compareCycle();
        exp_t ea, eb;
        if (sb_q.size() < 2) begin
            checkOutput("scoreboard_depth", 16'(sb_q.size()), 16'd2);
            return;
        end
        ea = sb_q.pop_front();
        eb = sb_q.pop_front();
        checkOutput($sformatf("A.MUXCOntrol c%0d", cycle), 16'(mux_a),        16'(ea.mux));
        checkOutput($sformatf("A.ID_Flush c%0d",   cycle), 16'(id_flush_a),   16'(ea.id_flush));
        checkOutput($sformatf("A.IF_Flush c%0d",   cycle), 16'(if_flush_a),   16'(ea.if_flush));
        checkOutput($sformatf("A.PC_Write c%0d",   cycle), 16'(pc_write_a),   16'(ea.pc_write));
        checkOutput($sformatf("A.IFID_Write c%0d", cycle), 16'(ifid_write_a), 16'(ea.ifid_write));
        checkOutput($sformatf("A.stall_cnt c%0d",  cycle), 16'(stall_cnt_a),  ea.stall_cnt);
        checkOutput($sformatf("A.flush_cnt c%0d",  cycle), 16'(flush_cnt_a),  ea.flush_cnt);
        checkOutput($sformatf("B.MUXCOntrol c%0d", cycle), 16'(mux_b),        16'(eb.mux));
        checkOutput($sformatf("B.ID_Flush c%0d",   cycle), 16'(id_flush_b),   16'(eb.id_flush));
        checkOutput($sformatf("B.IF_Flush c%0d",   cycle), 16'(if_flush_b),   16'(eb.if_flush));
        checkOutput($sformatf("B.PC_Write c%0d",   cycle), 16'(pc_write_b),   16'(eb.pc_write));
        checkOutput($sformatf("B.IFID_Write c%0d", cycle), 16'(ifid_write_b), 16'(eb.ifid_write));
        checkOutput($sformatf("B.stall_cnt c%0d",  cycle), stall_cnt_b,       eb.stall_cnt);
        checkOutput($sformatf("B.flush_cnt c%0d",  cycle), flush_cnt_b,       eb.flush_cnt);
    endtask

    // Inputs change at the falling edge, so a reset here lands between active edges.
    task automatic applyStimulus(input logic rst, input logic [31:0] ins, input logic mr,
                                 input logic [4:0] rte, input logic br, input logic jp);
        @(negedge clock);
        reset       = rst;
        instr_id    = ins;
        mem_read_ex = mr;
        rt_ex       = rte;
        branch_mem  = br;
        jump_id     = jp;
        sb_q.push_back(model_step(0));
        sb_q.push_back(model_step(1));
        #2;
        compareCycle();
        cycle++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    localparam logic [31:0] ADD_9_8_10  = 32'h010A4820;
    localparam logic [31:0] ADDI_8_8_5  = 32'h21080005;
    localparam logic [31:0] ADDI_9_8_5  = 32'h21090005;
    localparam logic [31:0] SW_9_0_8    = 32'hAD090000;
    localparam logic [31:0] J_TARGET    = 32'h08000010;

    initial begin
        logic [31:0] r_ins;
        $display("[TB] hazard_ctrl_unit scoreboard run");

        // Reset held while every hazard source is active.
        applyStimulus(1'b1, ADD_9_8_10, 1'b1, 5'd8, 1'b1, 1'b1);
        applyStimulus(1'b1, 32'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        idle(2);

        // Load-use hazards and non-hazards.
        applyStimulus(1'b0, ADD_9_8_10, 1'b1, 5'd8, 1'b0, 1'b0);
        idle(4);
        applyStimulus(1'b0, ADD_9_8_10, 1'b1, 5'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, ADDI_8_8_5, 1'b1, 5'd8, 1'b0, 1'b0);
        idle(4);
        applyStimulus(1'b0, ADDI_8_8_5, 1'b1, 5'd9, 1'b0, 1'b0);
        applyStimulus(1'b0, ADDI_9_8_5, 1'b1, 5'd9, 1'b0, 1'b0);
        applyStimulus(1'b0, SW_9_0_8,   1'b1, 5'd9, 1'b0, 1'b0);
        idle(4);
        applyStimulus(1'b0, ADD_9_8_10, 1'b0, 5'd8, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'd0,      1'b1, 5'd8, 1'b0, 1'b0);

        // Jump and branch flushes.
        applyStimulus(1'b0, J_TARGET, 1'b0, 5'd0, 1'b0, 1'b1);
        idle(2);
        applyStimulus(1'b0, 32'd0, 1'b0, 5'd0, 1'b1, 1'b0);
        idle(3);

        // Branch and hazard together; then branch arriving during a stall.
        applyStimulus(1'b0, ADD_9_8_10, 1'b1, 5'd8, 1'b1, 1'b0);
        idle(3);
        applyStimulus(1'b0, ADD_9_8_10, 1'b1, 5'd8, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'd0, 1'b0, 5'd0, 1'b1, 1'b0);
        idle(4);

        // Back-to-back branches, and hazard/jump ignored while flushing.
        applyStimulus(1'b0, 32'd0, 1'b0, 5'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'd0, 1'b0, 5'd0, 1'b1, 1'b0);
        idle(3);
        applyStimulus(1'b0, 32'd0, 1'b0, 5'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, ADD_9_8_10, 1'b1, 5'd8, 1'b0, 1'b1);
        idle(2);

        // Reset in the middle of the first flush cycle.
        applyStimulus(1'b0, 32'd0, 1'b0, 5'd0, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        idle(3);

        // Counter saturation.
        applyStimulus(1'b1, 32'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        for (int k = 0; k < 17; k++) begin
            applyStimulus(1'b0, ADD_9_8_10, 1'b1, 5'd8, 1'b0, 1'b0);
            idle(3);
        end
        for (int k = 0; k < 20; k++) applyStimulus(1'b0, J_TARGET, 1'b0, 5'd0, 1'b0, 1'b1);
        idle(2);

        // Random mix with small register numbers to provoke matches.
        for (int k = 0; k < 120; k++) begin
            r_ins = {ops[$urandom_range(0, 6)], 5'($urandom_range(0, 3)),
                     5'($urandom_range(0, 3)), 16'($urandom)};
            applyStimulus($urandom_range(0, 39) == 0, r_ins, $urandom_range(0, 1) == 1,
                          5'($urandom_range(0, 3)), $urandom_range(0, 5) == 0,
                          $urandom_range(0, 4) == 0);
        end
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

endmodule
